// File: rtl/core_run_ctrl_if.sv
// Host/core-facing signal bundle of the run sequencer.
// The master side drives launch/abort/done; the slave (the sequencer) drives status and core controls.
interface core_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             core_done;
  logic             core_rst;
  logic             core_en;
  logic             busy;
  logic             run_done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state;

  modport master (
    output start, abort, core_done,
    input  core_rst, core_en, busy, run_done, timeout, cycle_count, state
  );

  modport slave (
    input  start, abort, core_done,
    output core_rst, core_en, busy, run_done, timeout, cycle_count, state
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run sequencer: launch on start edge, hold core in reset RST_CYCLES, run until done/abort/watchdog.
// All outputs registered (one-edge latency from inputs); no backpressure, host polls state/flags.
module core_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic           clk_i,
  input  logic           reset_i,
  core_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HOLD = 3'd1,
    S_RUN  = 3'd2,
    S_DONE = 3'd3,
    S_TOUT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;
  logic             start_q;
  logic             core_rst_q, core_en_q, busy_q;

  logic             launch;
  logic [CNT_W:0]   cnt_inc;
  logic             cnt_sat;
  logic             limit_hit;

  assign launch    = bus.start & ~start_q;
  assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat   = &cnt_q;
  assign limit_hit = (MAX_CYCLES != 0) && (cnt_inc == (CNT_W+1)'(MAX_CYCLES));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    tout_d  = tout_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_HOLD;
          hold_d  = 4'd0;
          cnt_d   = '0;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      S_HOLD: begin
        hold_d = hold_q + 4'd1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (hold_q == 4'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The exit cycle is still a RUN cycle, so the count advances on every branch.
        cnt_d = cnt_sat ? cnt_q : cnt_inc[CNT_W-1:0];
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.core_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (limit_hit) begin
          state_d = S_TOUT;
          tout_d  = 1'b1;
        end
      end
      S_DONE, S_TOUT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end else if (launch) begin
          state_d = S_HOLD;
          hold_d  = 4'd0;
          cnt_d   = '0;
          done_d  = 1'b0;
          tout_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      hold_q     <= 4'd0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      start_q    <= 1'b1;
      core_rst_q <= 1'b1;
      core_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
      start_q    <= bus.start;
      core_rst_q <= (state_d == S_IDLE) || (state_d == S_HOLD);
      core_en_q  <= (state_d == S_RUN);
      busy_q     <= (state_d == S_HOLD) || (state_d == S_RUN);
    end
  end

  assign bus.core_rst    = core_rst_q;
  assign bus.core_en     = core_en_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = done_q;
  assign bus.timeout     = tout_q;
  assign bus.cycle_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: two instances (16-bit/limit 50, 4-bit/no watchdog) checked each cycle against a phase model.
module tb_core_run_ctrl;

  localparam int RST = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;

  core_run_ctrl_if #(.CNT_W(16)) b0 ();
  core_run_ctrl_if #(.CNT_W(4))  b1 ();

  core_run_ctrl #(.RST_CYCLES(RST), .CNT_W(16), .MAX_CYCLES(50)) u0 (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (b0.slave)
  );

  core_run_ctrl #(.RST_CYCLES(RST), .CNT_W(4), .MAX_CYCLES(0)) u1 (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (b1.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;        // 0 idle, 1 hold, 2 run, 3 done, 4 timeout
    int hold_left;
    int cnt;
    bit rd;
    bit to;
    bit ps;
  } mdl_t;

  mdl_t m0, m1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ph = 0; m.hold_left = 0; m.cnt = 0; m.rd = 0; m.to = 0; m.ps = 1;
    return m;
  endfunction

  task automatic mdl_launch(inout mdl_t m);
    m.ph = 1; m.hold_left = RST; m.cnt = 0; m.rd = 0; m.to = 0;
  endtask

  task automatic mdl_step(inout mdl_t m, input bit s, input bit a, input bit d,
                          input int maxc, input int cmax);
    bit launch;
    launch = s && !m.ps;
    m.ps   = s;
    case (m.ph)
      0: if (launch) mdl_launch(m);
      1: begin
        m.hold_left--;
        if (a) m.ph = 0;
        else if (m.hold_left == 0) m.ph = 2;
      end
      2: begin
        if (m.cnt < cmax) m.cnt++;
        if (a) m.ph = 0;
        else if (d) begin m.ph = 3; m.rd = 1; end
        else if (maxc != 0 && m.cnt == maxc) begin m.ph = 4; m.to = 1; end
      end
      default: begin
        if (a) begin m.ph = 0; m.rd = 0; m.to = 0; end
        else if (launch) mdl_launch(m);
      end
    endcase
  endtask

  task automatic mdl_cmp(input string tag, input mdl_t m, input int st, input bit cr,
                         input bit ce, input bit bz, input bit rd, input bit to, input int cnt);
    chk({tag, ".state"},       st,  m.ph);
    chk({tag, ".core_rst"},    int'(cr), int'(m.ph == 0 || m.ph == 1));
    chk({tag, ".core_en"},     int'(ce), int'(m.ph == 2));
    chk({tag, ".busy"},        int'(bz), int'(m.ph == 1 || m.ph == 2));
    chk({tag, ".run_done"},    int'(rd), int'(m.rd));
    chk({tag, ".timeout"},     int'(to), int'(m.to));
    chk({tag, ".cycle_count"}, cnt, m.cnt);
    chk({tag, ".excl"},        int'(rd && to), 0);
  endtask

  // Per-cycle compare against the model; async reset is also checked the instant it asserts.
  initial begin
    m0 = mdl_reset();
    m1 = mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m0 = mdl_reset();
        m1 = mdl_reset();
      end else begin
        mdl_step(m0, b0.start, b0.abort, b0.core_done, 50, 65535);
        mdl_step(m1, b1.start, b1.abort, b1.core_done, 0, 15);
      end
      #1;
      mdl_cmp("u0", m0, int'(b0.state), b0.core_rst, b0.core_en, b0.busy,
              b0.run_done, b0.timeout, int'(b0.cycle_count));
      mdl_cmp("u1", m1, int'(b1.state), b1.core_rst, b1.core_en, b1.busy,
              b1.run_done, b1.timeout, int'(b1.cycle_count));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start0();
    b0.start = 1'b1; tick(1); b0.start = 1'b0;
  endtask

  initial begin
    b0.start = 1'b1; b0.abort = 1'b0; b0.core_done = 1'b0;
    b1.start = 1'b1; b1.abort = 1'b0; b1.core_done = 1'b0;
    tick(3);
    chk("rst.state", int'(b0.state), 0);
    chk("rst.core_rst", int'(b0.core_rst), 1);
    rst_n = 1'b1;

    // start held high through reset release must not launch
    tick(3);
    chk("held_start.state", int'(b0.state), 0);
    chk("held_start.core_rst", int'(b0.core_rst), 1);
    b0.start = 1'b0; b1.start = 1'b0;
    tick(1);

    // launch, two HOLD cycles, then RUN
    pulse_start0();
    chk("hold1.state", int'(b0.state), 1);
    tick(1);
    chk("hold2.state", int'(b0.state), 1);
    tick(1);
    chk("run.state", int'(b0.state), 2);
    chk("run.core_en", int'(b0.core_en), 1);

    // done on 37th RUN cycle
    tick(36);
    b0.core_done = 1'b1; tick(1); b0.core_done = 1'b0;
    chk("done37.state", int'(b0.state), 3);
    chk("done37.count", int'(b0.cycle_count), 37);
    chk("done37.run_done", int'(b0.run_done), 1);
    b0.core_done = 1'b1; tick(3); b0.core_done = 1'b0;
    tick(17);
    chk("done37.hold_count", int'(b0.cycle_count), 37);
    chk("done37.hold_state", int'(b0.state), 3);

    // relaunch from DONE, second start edge in RUN ignored, then watchdog
    pulse_start0();
    chk("relaunch.count", int'(b0.cycle_count), 0);
    chk("relaunch.run_done", int'(b0.run_done), 0);
    tick(2);
    tick(2);
    pulse_start0();
    tick(1);
    chk("restart_ignored.state", int'(b0.state), 2);
    chk("restart_ignored.count", int'(b0.cycle_count), 4);
    tick(45);
    chk("pre_tout.state", int'(b0.state), 2);
    tick(1);
    chk("tout.state", int'(b0.state), 4);
    chk("tout.count", int'(b0.cycle_count), 50);
    chk("tout.timeout", int'(b0.timeout), 1);
    tick(5);
    b0.abort = 1'b1; tick(1); b0.abort = 1'b0;
    chk("tout_abort.timeout", int'(b0.timeout), 0);

    // done coinciding with the limit cycle wins
    pulse_start0();
    tick(2);
    tick(49);
    b0.core_done = 1'b1; tick(1); b0.core_done = 1'b0;
    chk("done50.state", int'(b0.state), 3);
    chk("done50.timeout", int'(b0.timeout), 0);
    chk("done50.count", int'(b0.cycle_count), 50);

    // abort on 10th RUN cycle, then abort in HOLD
    pulse_start0();
    tick(2);
    tick(9);
    b0.abort = 1'b1; tick(1); b0.abort = 1'b0;
    chk("abort_run.state", int'(b0.state), 0);
    chk("abort_run.core_rst", int'(b0.core_rst), 1);
    chk("abort_run.count", int'(b0.cycle_count), 10);
    pulse_start0();
    b0.abort = 1'b1; tick(1); b0.abort = 1'b0;
    chk("abort_hold.state", int'(b0.state), 0);

    // async reset in the 5th RUN cycle
    tick(1);
    pulse_start0();
    tick(2);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.state", int'(b0.state), 0);
    chk("areset.core_rst", int'(b0.core_rst), 1);
    chk("areset.count", int'(b0.cycle_count), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // no watchdog, 4-bit counter saturates at 15
    b1.start = 1'b1; tick(1); b1.start = 1'b0;
    tick(2);
    tick(20);
    chk("sat.state", int'(b1.state), 2);
    chk("sat.count", int'(b1.cycle_count), 15);
    chk("sat.timeout", int'(b1.timeout), 0);
    b1.core_done = 1'b1; tick(1); b1.core_done = 1'b0;
    chk("sat_done.state", int'(b1.state), 3);
    chk("sat_done.count", int'(b1.cycle_count), 15);
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run sequencer for the Pebble processor core.
- Launches a program run on a host start edge and holds the core in reset for a fixed number of cycles.
- Releases the core, counts execution cycles and waits for the core's done flag.
- Aborts with a timeout status if the run exceeds a cycle limit.
- Sits between the host/testbench and the core's reset/clock-enable pins; the core's done output is an input here.

Parameters:
RST_CYCLES, 2, cycles core_rst is held after launch (legal range 1..15).
CNT_W, 16, width of the cycle counter.
MAX_CYCLES, 1000, watchdog limit in RUN cycles. 0 disables the watchdog. Must be ≤ 2^CNT_W-1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  host launch request; rising edge triggers a run
abort  input  1  host abort, level, sampled synchronously
core_done  input  1  done flag from the core
core_rst  output  1  active-high reset to the core
core_en  output  1  core clock enable (PC/RF/DM advance only when high)
busy  output  1  high in HOLD and RUN
run_done  output  1  run completed normally; sticky until next launch or abort
timeout  output  1  watchdog fired; sticky until next launch or abort
cycle_count  output  CNT_W  RUN cycles consumed by the last/current run
state  output  3  FSM state code: IDLE=0, HOLD=1, RUN=2, DONE=3, TOUT=4

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (reset=0, asynchronous), forced immediately:
  - state=IDLE, core_rst=1, core_en=0, busy=0, run_done=0, timeout=0, cycle_count=0.
  - Internal start_q=1, hold counter=0.
  - Because start_q resets to 1, a start held high through reset release does not launch.
- Launch condition at an edge: start=1 and start_q=0. start_q <= start on every edge.
- IDLE: core_rst=1, core_en=0.
  - Launch -> HOLD. Clear cycle_count, run_done and timeout. Hold counter <= 0.
- HOLD: core_rst=1, core_en=0, busy=1.
  - Hold counter increments each cycle.
  - At hold counter == RST_CYCLES-1 -> RUN (core_rst=0 and core_en=1 from that edge).
  - Net effect: RUN is entered RST_CYCLES edges after the launch edge.
- RUN: core_rst=0, core_en=1, busy=1. cycle_count increments every RUN cycle, including the cycle in which core_done is sampled.
  - Priority, highest first:
    1. abort -> IDLE (core_rst=1; run_done and timeout stay 0).
    2. core_done=1 -> DONE, run_done=1.
    3. MAX_CYCLES≠0 and cycle_count+1 == MAX_CYCLES -> TOUT, timeout=1.
  - If core_done coincides with the limit cycle, the result is DONE, not TOUT.
- DONE: core_rst=0, core_en=0 (core state frozen for host readback), busy=0.
  - cycle_count holds its value.
  - Launch -> HOLD (clears flags and count). abort -> IDLE, clears run_done.
- TOUT: same as DONE, but with timeout=1 instead of run_done.
- In HOLD, abort -> IDLE. In IDLE, abort has no effect.
- A launch edge during HOLD or RUN is ignored (no restart).
- core_done is ignored outside RUN.
- cycle_count never wraps: the watchdog bounds it. With MAX_CYCLES=0, cycle_count saturates at 2^CNT_W-1.
- run_done and timeout are never both 1.
- Asynchronous reset mid-run returns to IDLE with the core held in reset; no status is retained.

Test Plan:
1. Reset release with start held 1 -> state stays IDLE, core_rst=1. Drop start, pulse start 1 cycle -> HOLD for exactly 2 cycles (RST_CYCLES=2), then RUN with core_rst=0, core_en=1.
2. Normal run: core_done asserted on the 37th RUN cycle -> DONE next edge, run_done=1, cycle_count=37, core_en=0, busy=0. Values hold for 20 further cycles.
3. Watchdog: MAX_CYCLES=50, core_done never asserted -> TOUT after the 50th RUN cycle, timeout=1, cycle_count=50, run_done=0. Repeat with core_done asserted exactly on cycle 50 -> DONE, run_done=1, timeout=0.
4. Abort: assert abort on the 10th RUN cycle -> IDLE next edge, core_rst=1, run_done=0, timeout=0. Abort during HOLD -> IDLE.
5. Relaunch: from DONE, pulse start -> flags and cycle_count clear, HOLD then RUN. A second start edge during RUN is ignored. Async reset in the 5th RUN cycle -> immediate IDLE, all outputs at reset values.
6. MAX_CYCLES=0, CNT_W=4 -> cycle_count saturates at 15, no timeout; later core_done -> DONE with cycle_count=15.
